// File: rtl/riscv_if_pkg.sv
// Shared types for the instruction prefetch queue: queue entry layout and counter sizing.
package riscv_if_pkg;
   localparam int unsigned IFQ_XLEN = 32;

   typedef struct packed {
      logic [IFQ_XLEN-1:0] parcel;
      logic [IFQ_XLEN-1:0] pc;
      logic                misaligned;
      logic                page_fault;
      logic                error;
   } ifq_entry_t;

   // Occupancy/outstanding counters must be able to hold the value DEPTH itself.
   function automatic int unsigned ifq_cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/riscv_if_prefetch_if.sv
// Instruction-side bus: req/rdy request handshake, in-order responses qualified by ack.
interface riscv_if_prefetch_if #(parameter int unsigned XLEN = 32);
   logic            imem_req;
   logic [XLEN-1:0] imem_adr;
   logic            imem_rdy;
   logic            imem_ack;
   logic [XLEN-1:0] imem_q;
   logic            imem_err;
   logic            imem_misaligned;
   logic            imem_page_fault;

   modport master (
      output imem_req, imem_adr,
      input  imem_rdy, imem_ack, imem_q, imem_err, imem_misaligned, imem_page_fault
   );

   modport slave (
      input  imem_req, imem_adr,
      output imem_rdy, imem_ack, imem_q, imem_err, imem_misaligned, imem_page_fault
   );
endinterface

// File: rtl/riscv_ifq_fifo.sv
// DEPTH-entry circular buffer of prefetched words, 1 cycle write-to-read.
// No internal backpressure: the caller never pushes when full; clear wins over push/pop.
module riscv_ifq_fifo
   import riscv_if_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = ifq_cnt_w(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          push_i,
   input  ifq_entry_t    wdat_i,
   input  logic          pop_i,
   output ifq_entry_t    rdat_o,
   output logic [CW-1:0] cnt_o
);
   localparam int unsigned PW = $clog2(DEPTH);

   ifq_entry_t    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Power-of-two depth lets the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
         cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdat_i;
   end

   assign rdat_o = mem_q[rd_ptr_q];
   assign cnt_o  = cnt_q;
endmodule

// File: rtl/riscv_if_prefetch.sv
// Instruction prefetch queue: sequential fetch, in-order buffering, flush/restart. Ack-to-valid 1 cycle,
// 0 on an empty queue with RV12_IFQ_BYPASS_EN; issue stops once outstanding+queued reaches DEPTH.
module riscv_if_prefetch
   import riscv_if_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     PARCEL_SIZE = 32,
   parameter logic [XLEN-1:0] PC_INIT     = 'h200,
   parameter int unsigned     DEPTH       = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   riscv_if_prefetch_if.master       imem,
   input  logic [XLEN-1:0]           if_nxt_pc_i,
   input  logic                      if_flush_i,
   input  logic                      if_stall_i,
   output logic                      if_stall_nxt_pc_o,
   output logic [PARCEL_SIZE-1:0]    if_parcel_o,
   output logic [XLEN-1:0]           if_parcel_pc_o,
   output logic [PARCEL_SIZE/16-1:0] if_parcel_valid_o,
   output logic                      if_parcel_misaligned_o,
   output logic                      if_parcel_page_fault_o,
   output logic                      if_parcel_error_o
);
   localparam int unsigned   CW      = ifq_cnt_w(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
   localparam logic [CW:0]   DEPTH_X = DEPTH[CW:0];

   logic [CW-1:0]   outst_q, outst_d, disc_q, disc_d, cnt;
   logic [XLEN-1:0] adr_q, adr_d, rsp_pc_q, rsp_pc_d, flush_pc;
   logic [CW:0]     credit;
   logic            ack, drop, live, accept, byp, head_vld, pop, push;
   ifq_entry_t      ack_ent, head_ent, out_ent;

   assign flush_pc = {if_nxt_pc_i[XLEN-1:2], 2'b00};

   // An ack with nothing outstanding (e.g. left over from before reset) is ignored.
   assign ack  = imem.imem_ack & (outst_q != '0);
   assign drop = ack & (disc_q != '0);
   assign live = ack & (disc_q == '0);

   // Responses still owed to the live stream plus queued words must fit in the queue.
   assign credit        = {1'b0, outst_q} - {1'b0, disc_q} + {1'b0, cnt};
   assign imem.imem_req = rst_ni & ~if_flush_i & (credit < DEPTH_X) & (outst_q < DEPTH_C);
   assign imem.imem_adr = adr_q;
   assign accept        = imem.imem_req & imem.imem_rdy;

   assign ack_ent = '{parcel:     imem.imem_q,
                      pc:         rsp_pc_q,
                      misaligned: imem.imem_misaligned,
                      page_fault: imem.imem_page_fault,
                      error:      imem.imem_err};

`ifdef RV12_IFQ_BYPASS_EN
   assign byp = live & ~if_flush_i & (cnt == '0);
`else
   assign byp = 1'b0;
`endif

   assign head_vld = ~if_flush_i & ((cnt != '0) | byp);
   assign pop      = (cnt != '0) & ~if_flush_i & ~if_stall_i;
   assign push     = live & ~if_flush_i & ~(byp & ~if_stall_i);
   assign out_ent  = byp ? ack_ent : head_ent;

   always_comb begin
      outst_d  = outst_q + CW'(accept) - CW'(ack);
      disc_d   = disc_q;
      adr_d    = adr_q;
      rsp_pc_d = rsp_pc_q;
      if (if_flush_i) begin
         disc_d   = outst_q - CW'(ack);
         adr_d    = flush_pc;
         rsp_pc_d = flush_pc;
      end else begin
         if (drop)   disc_d   = disc_q - CW'(1);
         if (accept) adr_d    = adr_q + XLEN'(4);
         if (live)   rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outst_q  <= '0;
         disc_q   <= '0;
         adr_q    <= PC_INIT;
         rsp_pc_q <= PC_INIT;
      end else begin
         outst_q  <= outst_d;
         disc_q   <= disc_d;
         adr_q    <= adr_d;
         rsp_pc_q <= rsp_pc_d;
      end
   end

   riscv_ifq_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (if_flush_i),
      .push_i (push),
      .wdat_i (ack_ent),
      .pop_i  (pop),
      .rdat_o (head_ent),
      .cnt_o  (cnt)
   );

   // Head fields read as zero whenever nothing valid is presented.
   assign if_stall_nxt_pc_o      = (cnt == DEPTH_C);
   assign if_parcel_valid_o      = {(PARCEL_SIZE/16){head_vld}};
   assign if_parcel_o            = head_vld ? out_ent.parcel : '0;
   assign if_parcel_pc_o         = head_vld ? out_ent.pc : '0;
   assign if_parcel_misaligned_o = head_vld & out_ent.misaligned;
   assign if_parcel_page_fault_o = head_vld & out_ent.page_fault;
   assign if_parcel_error_o      = head_vld & out_ent.error;
endmodule

// File: tb/tb_riscv_if_prefetch.sv
// Bench for riscv_if_prefetch: directed vector table, corner sequences, randomized run vs a stream model.
module tb_riscv_if_prefetch;
   localparam int unsigned DEPTH   = 4;
   localparam logic [31:0] PC_INIT = 32'h200;
`ifdef RV12_IFQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] nxt_pc;
   logic        flush, stall, full, pmis, ppf, perr;
   logic [31:0] parcel, ppc;
   logic [1:0]  pvld;

   riscv_if_prefetch_if #(.XLEN(32)) bus ();

   riscv_if_prefetch #(.XLEN(32), .PARCEL_SIZE(32), .PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .imem                   (bus),
      .if_nxt_pc_i            (nxt_pc),
      .if_flush_i             (flush),
      .if_stall_i             (stall),
      .if_stall_nxt_pc_o      (full),
      .if_parcel_o            (parcel),
      .if_parcel_pc_o         (ppc),
      .if_parcel_valid_o      (pvld),
      .if_parcel_misaligned_o (pmis),
      .if_parcel_page_fault_o (ppf),
      .if_parcel_error_o      (perr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory contents and fault flags are pure functions of the word address.
   function automatic logic [31:0] mem_dat(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   function automatic logic [2:0] mem_flt(input logic [31:0] a);  // {misaligned, page_fault, error}
      return {a[6:2] == 5'd17, a[6:2] == 5'd1, a[6:2] == 5'd9};
   endfunction

   // Model: requests tagged with the fetch stream (epoch) they belong to.
   typedef struct { logic [31:0] adr; int ep; } req_t;
   req_t        pend[$];
   int          epoch, occ;
   logic [31:0] exp_adr, exp_pc;
   logic        s_req, s_vld, s_pf, s_full;
   logic [31:0] s_adr, s_pc;

   task automatic model_reset();
      pend.delete();
      epoch   = 0;
      occ     = 0;
      exp_adr = PC_INIT;
      exp_pc  = PC_INIT;
   endtask

   task automatic cyc(input bit rdy, input bit ack, input bit stl, input bit fl, input logic [31:0] npc);
      bit live, exp_req, exp_vld;
      int lo;
      bus.imem_rdy = rdy;
      bus.imem_ack = ack;
      stall        = stl;
      flush        = fl;
      nxt_pc       = npc;
      if (ack && pend.size() > 0) begin
         bus.imem_q = mem_dat(pend[0].adr);
         {bus.imem_misaligned, bus.imem_page_fault, bus.imem_err} = mem_flt(pend[0].adr);
      end else begin
         bus.imem_q = $urandom;
         {bus.imem_misaligned, bus.imem_page_fault, bus.imem_err} = 3'($urandom);
      end
      @(negedge clk);
      lo = 0;
      foreach (pend[i]) if (pend[i].ep == epoch) lo++;
      live    = ack && pend.size() > 0 && pend[0].ep == epoch && !fl;
      exp_req = !fl && (lo + occ < DEPTH) && (pend.size() < DEPTH);
      exp_vld = !fl && (occ > 0 || (BYP && live));
      check("req", bus.imem_req, exp_req);
      if (exp_req) check("adr", bus.imem_adr, exp_adr);
      check("valid", {30'b0, pvld}, exp_vld ? 32'h3 : 32'h0);
      check("full", full, occ == DEPTH);
      if (exp_vld) begin
         check("pc", ppc, exp_pc);
         check("parcel", parcel, mem_dat(exp_pc));
         check("flags", {29'b0, pmis, ppf, perr}, {29'b0, mem_flt(exp_pc)});
      end
      s_req = bus.imem_req; s_adr = bus.imem_adr; s_vld = pvld[0];
      s_pc = ppc; s_pf = ppf; s_full = full;
      if (ack && pend.size() > 0) void'(pend.pop_front());
      if (exp_req && rdy) begin
         pend.push_back('{adr: exp_adr, ep: epoch});
         exp_adr += 32'd4;
      end
      if (exp_vld && !stl) exp_pc += 32'd4;
      occ = occ + (live ? 1 : 0) - ((exp_vld && !stl) ? 1 : 0);
      if (fl) begin
         epoch++;
         occ     = 0;
         exp_adr = {npc[31:2], 2'b00};
         exp_pc  = {npc[31:2], 2'b00};
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((pend.size() > 0 || occ > 0) && n < 60) begin
         cyc(1'b0, pend.size() > 0, 1'b0, 1'b0, 32'h0);
         n++;
      end
      check("drain_done", (pend.size() > 0 || occ > 0), 0);
   endtask

   typedef struct {
      bit rdy, ack, stl;
      bit req; logic [31:0] adr; bit vld; logic [31:0] pc; bit pf; bit full;
   } vec_t;
   vec_t tbl [12];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit r, a, s, f;
      logic [31:0] np;
      // Back-pressure with 1-cycle acks: four requests then stop until a pop frees a slot.
      tbl[0]  = '{1,0,1, 1,32'h200,0,  32'h0,  0,0};
      tbl[1]  = '{1,1,1, 1,32'h204,BYP,32'h200,0,0};
      tbl[2]  = '{1,1,1, 1,32'h208,1,  32'h200,0,0};
      tbl[3]  = '{1,1,1, 1,32'h20C,1,  32'h200,0,0};
      tbl[4]  = '{1,1,1, 0,32'h210,1,  32'h200,0,0};
      tbl[5]  = '{1,0,1, 0,32'h210,1,  32'h200,0,1};
      tbl[6]  = '{1,0,1, 0,32'h210,1,  32'h200,0,1};
      tbl[7]  = '{1,0,0, 0,32'h210,1,  32'h200,0,1};
      tbl[8]  = '{1,0,1, 1,32'h210,1,  32'h204,1,0};
      tbl[9]  = '{1,1,0, 0,32'h214,1,  32'h204,1,0};
      tbl[10] = '{1,0,0, 1,32'h214,1,  32'h208,0,0};
      tbl[11] = '{1,1,0, 1,32'h218,1,  32'h20C,0,0};

      bus.imem_rdy = 1'b1; bus.imem_ack = 1'b0; bus.imem_q = '0;
      bus.imem_err = 1'b0; bus.imem_misaligned = 1'b0; bus.imem_page_fault = 1'b0;
      flush = 1'b0; stall = 1'b0; nxt_pc = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", bus.imem_req, 0);
      check("rst_adr", bus.imem_adr, PC_INIT);
      check("rst_valid", {30'b0, pvld}, 0);
      check("rst_full", full, 0);
      check("rst_parcel", parcel, 0);
      check("rst_pc", ppc, 0);
      check("rst_flags", {29'b0, pmis, ppf, perr}, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].rdy, tbl[i].ack, tbl[i].stl, 1'b0, 32'h0);
         check($sformatf("tbl%0d_req", i), s_req, tbl[i].req);
         check($sformatf("tbl%0d_adr", i), s_adr, tbl[i].adr);
         check($sformatf("tbl%0d_vld", i), s_vld, tbl[i].vld);
         check($sformatf("tbl%0d_full", i), s_full, tbl[i].full);
         if (tbl[i].vld) begin
            check($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
            check($sformatf("tbl%0d_pf", i), s_pf, tbl[i].pf);
         end
      end

      // Flush with three requests in flight.
      drain();
      repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h1002);
      check("fl3_req", s_req, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         check("fl3_stale_vld", s_vld, 0);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check("fl3_new_req", s_req, 1);
      check("fl3_new_adr", s_adr, 32'h1000);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("byp_same_cycle_vld", s_vld, BYP);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      check("byp_next_vld", s_vld, 1);
      check("fl3_new_pc", s_pc, 32'h1000);

      // Flush coincident with an ack, two outstanding: one more ack must be dropped.
      drain();
      repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h2000);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("coinc_drop_vld", s_vld, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check("coinc_req_adr", s_adr, 32'h2000);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      check("coinc_vld", s_vld, 1);
      check("coinc_pc", s_pc, 32'h2000);

      // Reset mid-transaction, then a stray ack after release.
      drain();
      repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      rst_n = 1'b0;
      #1;
      check("midrst_req", bus.imem_req, 0);
      check("midrst_adr", bus.imem_adr, PC_INIT);
      check("midrst_valid", {30'b0, pvld}, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("stray_ack_vld", s_vld, 0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      check("postrst_req", s_req, 1);
      check("postrst_adr", s_adr, PC_INIT);

      // Randomized traffic, including restarts near the top of the address space.
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 9) < 7);
         a  = (pend.size() > 0) && ($urandom_range(0, 9) < 6);
         s  = ($urandom_range(0, 9) < 4);
         f  = ($urandom_range(0, 99) < 4);
         np = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
         cyc(r, a, s, f, np);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
